// File: rtl/pha_pkg.sv
// Shared types and sizing helpers for the pulse-height analyser.
package pha_pkg;

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StHoldoff
    } pha_state_e;

    // Packed record layout: {height[DW], len[LW], pileup, overlong}.
    function automatic int unsigned rec_width(input int unsigned dw, input int unsigned lw);
        return dw + lw + 2;
    endfunction

endpackage

// File: rtl/pha_baseline.sv
// Exponential-average baseline tracker: acc += sample - acc/2^BL_SHIFT while not frozen.
module pha_baseline #(
    parameter int unsigned DW       = 14,
    parameter int unsigned BL_SHIFT = 4,
    parameter int unsigned BL_INIT  = 0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          freeze_i,
    input  logic [DW-1:0] sample_i,
    output logic [DW-1:0] baseline_o
);

    localparam int unsigned AW = DW + BL_SHIFT;
    localparam logic [AW-1:0] AccInit = AW'(BL_INIT) << BL_SHIFT;

    logic [AW-1:0] acc_q, acc_d;

    assign baseline_o = acc_q[AW-1:BL_SHIFT];

    // acc >= baseline << BL_SHIFT, so the subtraction never underflows.
    always_comb begin
        acc_d = acc_q;
        if (!freeze_i) begin
            acc_d = acc_q - AW'(baseline_o) + AW'(sample_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= AccInit;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/pulse_height_analyzer.sv
// Baseline-subtracted pulse detector emitting one {height, len, pileup, overlong}
// record per pulse over valid/ready, with event and drop counters.
module pulse_height_analyzer
    import pha_pkg::*;
#(
    parameter int unsigned DW       = 14,
    parameter int unsigned BL_SHIFT = 4,
    parameter int unsigned BL_INIT  = 0,
    parameter int unsigned LW       = 10,
    parameter int unsigned HOLDOFF  = 16
) (
    input  logic             CLOCK_65,
    input  logic             rst,
    input  logic             en,
    input  logic             ad_valid,
    input  logic [DW-1:0]    ad_data,
    input  logic [DW-1:0]    threshold,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    pulse_height,
    output logic [LW-1:0]    pulse_len,
    output logic             pileup,
    output logic             overlong,
    output logic [DW-1:0]    baseline,
    output logic [CNT_W-1:0] event_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int unsigned RecW = rec_width(DW, LW);
    localparam int unsigned HW   = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [LW-1:0] MaxLen   = '1;
    localparam logic [HW-1:0] HoldInit = HW'(HOLDOFF);

    pha_state_e        state_q, state_d;
    logic [DW-1:0]     peak_q, peak_d, valley_q, valley_d;
    logic [LW-1:0]     len_q, len_d, len_inc;
    logic              pile_q, pile_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic              out_valid_q, out_valid_d;
    logic [RecW-1:0]   rec_q, rec_d;
    logic [CNT_W-1:0]  event_q, event_d, drop_q, drop_d;
    logic [DW-1:0]     amp;
    logic              emit, emit_ovl, bl_freeze;

    assign amp       = (ad_data > baseline) ? ad_data - baseline : '0;
    assign bl_freeze = !(en && ad_valid && (state_q == StIdle));
    assign len_inc   = len_q + 1'b1;

    pha_baseline #(
        .DW       (DW),
        .BL_SHIFT (BL_SHIFT),
        .BL_INIT  (BL_INIT)
    ) u_baseline (
        .clk_i      (CLOCK_65),
        .rst_i      (rst),
        .freeze_i   (bl_freeze),
        .sample_i   (ad_data),
        .baseline_o (baseline)
    );

    always_comb begin
        state_d  = state_q;
        peak_d   = peak_q;
        valley_d = valley_q;
        len_d    = len_q;
        pile_d   = pile_q;
        hold_d   = hold_q;
        emit     = 1'b0;
        emit_ovl = 1'b0;
        if (!en) begin
            state_d = StIdle;
            hold_d  = '0;
        end else if (ad_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (amp > threshold) begin
                        state_d  = StActive;
                        peak_d   = amp;
                        valley_d = amp;
                        len_d    = LW'(1);
                        pile_d   = 1'b0;
                    end
                end
                StActive: begin
                    if (amp <= threshold) begin
                        emit = 1'b1;
                    end else begin
                        len_d = len_inc;
                        if (amp >= peak_q) begin
                            peak_d   = amp;
                            valley_d = amp;
                        end else if (amp < valley_q) begin
                            valley_d = amp;
                        end
                        // A renewed rise of more than threshold off the valley, still below peak.
                        if (({1'b0, amp} > ({1'b0, valley_d} + {1'b0, threshold}))
                            && (amp < peak_d)) begin
                            pile_d = 1'b1;
                        end
                        if (len_inc == MaxLen) begin
                            emit     = 1'b1;
                            emit_ovl = 1'b1;
                        end
                    end
                    if (emit) begin
                        state_d = (HOLDOFF == 0) ? StIdle : StHoldoff;
                        hold_d  = HoldInit;
                    end
                end
                StHoldoff: begin
                    hold_d = hold_q - 1'b1;
                    if (hold_q <= HW'(1)) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        rec_d       = rec_q;
        event_d     = event_q;
        drop_d      = drop_q;
        if (emit) begin
            event_d = event_q + 1'b1;
            if (out_valid_q && !out_ready) begin
                if (drop_q != '1) begin
                    drop_d = drop_q + 1'b1;
                end
            end else begin
                out_valid_d = 1'b1;
                rec_d       = {peak_d, len_d, pile_d, emit_ovl};
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_65 or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            peak_q      <= '0;
            valley_q    <= '0;
            len_q       <= '0;
            pile_q      <= 1'b0;
            hold_q      <= '0;
            out_valid_q <= 1'b0;
            rec_q       <= '0;
            event_q     <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            peak_q      <= peak_d;
            valley_q    <= valley_d;
            len_q       <= len_d;
            pile_q      <= pile_d;
            hold_q      <= hold_d;
            out_valid_q <= out_valid_d;
            rec_q       <= rec_d;
            event_q     <= event_d;
            drop_q      <= drop_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign pulse_height = rec_q[RecW-1 -: DW];
    assign pulse_len    = rec_q[LW+1:2];
    assign pileup       = rec_q[1];
    assign overlong     = rec_q[0];
    assign event_cnt    = event_q;
    assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_pulse_height_analyzer.sv
// Scoreboard bench: directed ADC waveforms on a LW=10 and a LW=4 instance, records checked on handshake.
module tb_pulse_height_analyzer;

    typedef struct packed {
        logic [13:0] h;
        logic [9:0]  l;
        logic        p;
        logic        o;
    } rec_t;

    logic        CLOCK_65 = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        en4 = 1'b0;
    logic        ad_valid = 1'b0;
    logic [13:0] ad_data = '0;
    logic [13:0] threshold = 14'd100;
    logic        out_ready = 1'b1;

    logic        out_valid, pileup, overlong;
    logic [13:0] pulse_height, baseline;
    logic [9:0]  pulse_len;
    logic [15:0] event_cnt, drop_cnt;

    logic        out_valid4, pileup4, overlong4;
    logic [13:0] pulse_height4, baseline4;
    logic [3:0]  pulse_len4;
    logic [15:0] event_cnt4, drop_cnt4;

    rec_t q[$];
    rec_t q4[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 CLOCK_65 = ~CLOCK_65;

    pulse_height_analyzer #(
        .DW (14), .BL_SHIFT (4), .BL_INIT (1000), .LW (10), .HOLDOFF (16)
    ) dut (
        .CLOCK_65     (CLOCK_65),
        .rst          (rst),
        .en           (en),
        .ad_valid     (ad_valid),
        .ad_data      (ad_data),
        .threshold    (threshold),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .pulse_height (pulse_height),
        .pulse_len    (pulse_len),
        .pileup       (pileup),
        .overlong     (overlong),
        .baseline     (baseline),
        .event_cnt    (event_cnt),
        .drop_cnt     (drop_cnt)
    );

    pulse_height_analyzer #(
        .DW (14), .BL_SHIFT (4), .BL_INIT (1000), .LW (4), .HOLDOFF (16)
    ) dut4 (
        .CLOCK_65     (CLOCK_65),
        .rst          (rst),
        .en           (en4),
        .ad_valid     (ad_valid),
        .ad_data      (ad_data),
        .threshold    (threshold),
        .out_valid    (out_valid4),
        .out_ready    (out_ready),
        .pulse_height (pulse_height4),
        .pulse_len    (pulse_len4),
        .pileup       (pileup4),
        .overlong     (overlong4),
        .baseline     (baseline4),
        .event_cnt    (event_cnt4),
        .drop_cnt     (drop_cnt4)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_rec(input string tag, input rec_t exp, input int h, input int l,
                           input int p, input int o);
        chk({tag, ".height"}, h, int'(exp.h));
        chk({tag, ".len"}, l, int'(exp.l));
        chk({tag, ".pileup"}, p, int'(exp.p));
        chk({tag, ".overlong"}, o, int'(exp.o));
    endtask

    always @(negedge CLOCK_65) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_record", 1, 0);
            end else begin
                cmp_rec("rec", q.pop_front(), int'(pulse_height), int'(pulse_len),
                        int'(pileup), int'(overlong));
            end
        end
    end

    always @(negedge CLOCK_65) begin
        if (!rst && out_valid4 && out_ready) begin
            if (q4.size() == 0) begin
                chk("unexpected_record4", 1, 0);
            end else begin
                cmp_rec("rec4", q4.pop_front(), int'(pulse_height4), int'(pulse_len4),
                        int'(pileup4), int'(overlong4));
            end
        end
    end

    task automatic send(input int d);
        @(posedge CLOCK_65);
        #1;
        ad_data  = 14'(d);
        ad_valid = 1'b1;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge CLOCK_65);
            #1;
            ad_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge CLOCK_65);
        #1;
        rst      = 1'b1;
        ad_valid = 1'b0;
        repeat (2) @(posedge CLOCK_65);
        #1;
        rst = 1'b0;
        chk("reset.baseline", int'(baseline), 1000);
        chk("reset.out_valid", int'(out_valid), 0);
        chk("reset.event_cnt", int'(event_cnt), 0);
        chk("reset.drop_cnt", int'(drop_cnt), 0);
        chk("reset.baseline4", int'(baseline4), 1000);
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Flat input: baseline must stay put and nothing may be emitted.
        do_reset();
        repeat (200) send(1000);
        gap(3);
        chk("flat.baseline", int'(baseline), 1000);
        chk("flat.event_cnt", int'(event_cnt), 0);

        // Idle samples 1050 and 1300 pull baseline to 1003 then 1021 (frozen from then on).
        do_reset();
        q.push_back('{h: 14'd779, l: 10'd4, p: 1'b0, o: 1'b0});
        send(1050); send(1300); send(1800); send(1500); send(1200); send(1050);
        chk("single.out_valid_before", int'(out_valid), 0);
        send(1000);
        chk("single.out_valid_after", int'(out_valid), 1);
        chk("single.event_cnt", int'(event_cnt), 1);
        chk("single.baseline_frozen", int'(baseline), 1021);
        gap(20);

        // Baseline 1018 after the trigger: amps 282? no -- trigger amp 300, then 782, 382, 682.
        do_reset();
        q.push_back('{h: 14'd782, l: 10'd4, p: 1'b1, o: 1'b0});
        send(1300); send(1800); send(1400); send(1700); send(1000);
        gap(20);
        chk("pileup.event_cnt", int'(event_cnt), 1);

        // Overlong on LW=4: first pulse ends at sample 15, 16 holdoff, second at sample 46.
        en  = 1'b0;
        do_reset();
        en4 = 1'b1;
        q4.push_back('{h: 14'd1000, l: 10'd15, p: 1'b0, o: 1'b1});
        q4.push_back('{h: 14'd938, l: 10'd15, p: 1'b0, o: 1'b1});
        repeat (15) send(2000);
        gap(1);
        chk("overlong.first_event", int'(event_cnt4), 1);
        repeat (30) send(2000);
        gap(1);
        chk("overlong.holdoff_not_early", int'(event_cnt4), 1);
        send(2000);
        gap(1);
        chk("overlong.second_event", int'(event_cnt4), 2);
        chk("overlong.baseline4", int'(baseline4), 1121);
        gap(5);
        en4 = 1'b0;
        en  = 1'b1;

        // Backpressure: A held, B dropped, C replaces A in the cycle A is accepted.
        do_reset();
        out_ready = 1'b0;
        q.push_back('{h: 14'd782, l: 10'd2, p: 1'b0, o: 1'b0});
        q.push_back('{h: 14'd552, l: 10'd1, p: 1'b0, o: 1'b0});
        send(1300); send(1800); send(1000);
        repeat (16) send(1000);
        send(1500); send(1000);
        gap(1);
        chk("bp.drop_cnt", int'(drop_cnt), 1);
        chk("bp.held_valid", int'(out_valid), 1);
        chk("bp.held_height", int'(pulse_height), 782);
        chk("bp.held_len", int'(pulse_len), 2);
        repeat (16) send(1000);
        send(1600); send(1000);
        out_ready = 1'b1;
        gap(1);
        chk("bp.new_height", int'(pulse_height), 552);
        chk("bp.drop_after", int'(drop_cnt), 1);
        chk("bp.event_cnt", int'(event_cnt), 3);
        gap(5);

        // Abort by en=0 mid-pulse, then asynchronous reset mid-pulse.
        do_reset();
        send(1300); send(1800); send(1900);
        en = 1'b0;
        send(1000);
        en = 1'b1;
        repeat (5) send(1000);
        gap(2);
        chk("abort.event_cnt", int'(event_cnt), 0);
        chk("abort.out_valid", int'(out_valid), 0);
        send(1300); send(1800);
        #2;
        rst = 1'b1;
        #1;
        chk("rst.baseline", int'(baseline), 1000);
        chk("rst.event_cnt", int'(event_cnt), 0);
        chk("rst.drop_cnt", int'(drop_cnt), 0);
        chk("rst.out_valid", int'(out_valid), 0);
        @(posedge CLOCK_65);
        #1;
        rst = 1'b0;
        ad_valid = 1'b0;
        repeat (5) send(1000);
        gap(3);
        chk("rst.no_record", int'(event_cnt), 0);

        gap(5);
        chk("queue.drained", q.size(), 0);
        chk("queue4.drained", q4.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
